// File: rtl/vga_sync_gen_if.sv
// Bus between the H/V counters and the sync/timing decoder.
// The master side drives the count values and pixel enable; the slave side
// (the decoder) returns syncs, video flag, coordinates, address and strobes.
interface vga_sync_gen_if;
    logic        en;
    logic [15:0] H_Count_Value;
    logic [15:0] V_Count_Value;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [18:0] fb_addr;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output en, H_Count_Value, V_Count_Value,
        input  hsync, vsync, video_on, pixel_x, pixel_y, fb_addr,
               line_start, frame_start, frame_count
    );

    modport slave (
        input  en, H_Count_Value, V_Count_Value,
        output hsync, vsync, video_on, pixel_x, pixel_y, fb_addr,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing decoder: turns free-running H/V counts into active-low syncs,
// active-video flag, pixel coordinates, a linear framebuffer address and
// line/frame strobes, all delayed PIPE_DEPTH enabled steps (legal 1..3) so
// they line up with framebuffer read data.
module vga_sync_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 32,
    parameter int PIPE_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    vga_sync_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    typedef struct packed {
        logic        hsync_n;
        logic        vsync_n;
        logic        video_on;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [18:0] addr;
        logic        ls;
        logic        fs;
    } stage_t;

    // Blanked, syncs released, no strobes: what a cleared stage holds.
    localparam stage_t IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, default: '0};

    logic [15:0] h, v;
    logic        in_range, active, frame_origin;
    logic [18:0] addr_cnt, addr_cur;
    stage_t      dec;

    stage_t [PIPE_DEPTH-1:0] pipe;
    stage_t [PIPE_DEPTH-1:0] stg_in;

    logic        fresh;      // last clk edge advanced the pipeline
    logic        fs_seen;    // first emitted frame_start after reset consumed
    logic [15:0] frame_cnt;

    assign h = bus.H_Count_Value;
    assign v = bus.V_Count_Value;

    // Decode one sample; anything past the line/frame totals is plain blanking.
    always_comb begin
        in_range     = (h < 16'(H_TOTAL)) && (v < 16'(V_TOTAL));
        active       = (h < 16'(H_ACTIVE)) && (v < 16'(V_ACTIVE));
        frame_origin = (h == 16'd0) && (v == 16'd0);
        // The origin restarts the address so the emitted value there is 0.
        addr_cur     = frame_origin ? 19'd0 : addr_cnt;

        dec          = IDLE;
        dec.hsync_n  = !(in_range && (h >= 16'(HS_BEG)) && (h < 16'(HS_END)));
        dec.vsync_n  = !(in_range && (v >= 16'(VS_BEG)) && (v < 16'(VS_END)));
        if (active) begin
            dec.video_on = 1'b1;
            dec.px       = h[9:0];
            dec.py       = v[9:0];
            dec.addr     = addr_cur;
        end
        dec.ls = in_range && (h == 16'd0);
        dec.fs = frame_origin;
    end

    // Running address: restarts at the frame origin, steps once per active pixel.
    always_ff @(posedge clk) begin
        if (!rst)
            addr_cnt <= '0;
        else if (bus.en)
            addr_cnt <= active ? addr_cur + 19'd1 : addr_cur;
    end

    // Input of each stage: the decoder feeds stage 0, each later stage its predecessor.
    always_comb begin
        stg_in[0] = dec;
        for (int i = 1; i < PIPE_DEPTH; i++)
            stg_in[i] = pipe[i-1];
    end

    // Delay line; every stage moves together on the pixel enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++)
                pipe[i] <= IDLE;
        end else if (bus.en) begin
            for (int i = 0; i < PIPE_DEPTH; i++)
                pipe[i] <= stg_in[i];
        end
    end

    // Strobe qualifier and frame counter, both tracking what reaches the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fresh     <= 1'b0;
            fs_seen   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            fresh <= bus.en;
            if (bus.en && stg_in[PIPE_DEPTH-1].fs) begin
                if (fs_seen)
                    frame_cnt <= frame_cnt + 16'd1;
                fs_seen <= 1'b1;
            end
        end
    end

    assign bus.hsync       = pipe[PIPE_DEPTH-1].hsync_n;
    assign bus.vsync       = pipe[PIPE_DEPTH-1].vsync_n;
    assign bus.video_on    = pipe[PIPE_DEPTH-1].video_on;
    assign bus.pixel_x     = pipe[PIPE_DEPTH-1].px;
    assign bus.pixel_y     = pipe[PIPE_DEPTH-1].py;
    assign bus.fb_addr     = pipe[PIPE_DEPTH-1].addr;
    // Strobes last one clk: the final stage holds under en=0 but fresh drops.
    assign bus.line_start  = pipe[PIPE_DEPTH-1].ls & fresh;
    assign bus.frame_start = pipe[PIPE_DEPTH-1].fs & fresh;
    assign bus.frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (PIPE_DEPTH 1, 2, 3) share one
// stimulus stream. The driver pushes the expected output of every enabled
// sample into a per-instance queue; the monitor pops once an instance's
// pipeline is full and otherwise expects held levels with strobes low.
module tb_vga_sync_gen;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [18:0] addr;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, default: '0};

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        en_in = 1'b1;
    logic [15:0] h_in = '0;
    logic [15:0] v_in = '0;

    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;
    int   depth [3] = '{1, 2, 3};
    exp_t q [3][$];
    exp_t last [3];
    exp_t act [3];
    exp_t ex;
    logic mon_en, mon_rst;

    // model state owned by the driver
    int   m_addr = 0;
    int   fs_cnt = 0;

    // hand-computed address spot checks for a frame entered at the origin
    int   spot_x [4] = '{639, 0, 5, 639};
    int   spot_y [4] = '{0, 1, 2, 2};
    int   spot_a [4] = '{639, 640, 1285, 1919};

    always #5 clk = ~clk;

    vga_sync_gen_if bus1 ();
    vga_sync_gen_if bus2 ();
    vga_sync_gen_if bus3 ();

    assign bus1.en = en_in;  assign bus1.H_Count_Value = h_in;  assign bus1.V_Count_Value = v_in;
    assign bus2.en = en_in;  assign bus2.H_Count_Value = h_in;  assign bus2.V_Count_Value = v_in;
    assign bus3.en = en_in;  assign bus3.H_Count_Value = h_in;  assign bus3.V_Count_Value = v_in;

    vga_sync_gen #(.PIPE_DEPTH(1)) dut1 (.clk(clk), .rst(rst_in), .bus(bus1));
    vga_sync_gen #(.PIPE_DEPTH(2)) dut2 (.clk(clk), .rst(rst_in), .bus(bus2));
    vga_sync_gen #(.PIPE_DEPTH(3)) dut3 (.clk(clk), .rst(rst_in), .bus(bus3));

    assign act[0] = {bus1.hsync, bus1.vsync, bus1.video_on, bus1.pixel_x, bus1.pixel_y,
                     bus1.fb_addr, bus1.line_start, bus1.frame_start, bus1.frame_count};
    assign act[1] = {bus2.hsync, bus2.vsync, bus2.video_on, bus2.pixel_x, bus2.pixel_y,
                     bus2.fb_addr, bus2.line_start, bus2.frame_start, bus2.frame_count};
    assign act[2] = {bus3.hsync, bus3.vsync, bus3.video_on, bus3.pixel_x, bus3.pixel_y,
                     bus3.fb_addr, bus3.line_start, bus3.frame_start, bus3.frame_count};

    task automatic check(input int k, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs depth=%0d t=%0t: got hs=%b vs=%b von=%b x=%0d y=%0d addr=%0d ls=%b fs=%b fc=%0d; want hs=%b vs=%b von=%b x=%0d y=%0d addr=%0d ls=%b fs=%b fc=%0d",
                     depth[k], $time, a.hs, a.vs, a.von, a.px, a.py, a.addr, a.ls, a.fs, a.fc,
                     e.hs, e.vs, e.von, e.px, e.py, e.addr, e.ls, e.fs, e.fc);
        end
    endtask

    // Expected output for one enabled sample, queued for every instance.
    task automatic push_sample(input int h, input int v);
        exp_t e;
        bit   in_rng, act_px;
        in_rng = (h < 800) && (v < 524);
        act_px = (h < 640) && (v < 480);
        if (h == 0 && v == 0) begin
            m_addr = 0;
            fs_cnt++;
        end
        e      = RST_EXP;
        e.hs   = !(in_rng && h >= 656 && h <= 751);
        e.vs   = !(in_rng && (v == 490 || v == 491));
        e.von  = act_px;
        e.px   = act_px ? 10'(h) : 10'd0;
        e.py   = act_px ? 10'(v) : 10'd0;
        e.addr = act_px ? 19'(m_addr) : 19'd0;
        if (act_px) m_addr++;
        e.ls   = in_rng && (h == 0);
        e.fs   = (h == 0) && (v == 0);
        e.fc   = (fs_cnt == 0) ? 16'd0 : 16'(fs_cnt - 1);
        for (int k = 0; k < 3; k++) q[k].push_back(e);
    endtask

    task automatic step(input int h, input int v, input logic e);
        @(negedge clk);
        rst_in = 1'b1;
        en_in  = e;
        h_in   = 16'(h);
        v_in   = 16'(v);
        if (e) push_sample(h, v);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_in = 1'b0;
            en_in  = 1'b1;
            h_in   = 16'($urandom_range(0, 1023));
            v_in   = 16'($urandom_range(0, 1023));
        end
        m_addr = 0;
        fs_cnt = 0;
    endtask

    task automatic sweep_line(input int v);
        for (int h = 0; h < 800; h++) step(h, v, 1'b1);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        mon_en  = en_in;
        mon_rst = rst_in;
        #1;
        if (!mon_rst) begin
            started = 1'b1;
            for (int k = 0; k < 3; k++) begin
                q[k].delete();
                last[k] = RST_EXP;
                check(k, RST_EXP, act[k]);
            end
        end else if (started) begin
            for (int k = 0; k < 3; k++) begin
                if (mon_en && q[k].size() >= depth[k]) begin
                    ex = q[k].pop_front();
                end else begin
                    ex    = last[k];
                    ex.ls = 1'b0;
                    ex.fs = 1'b0;
                end
                check(k, ex, act[k]);
                last[k] = ex;
            end
            for (int i = 0; i < 4; i++) begin
                if (act[1].von && int'(act[1].px) == spot_x[i] && int'(act[1].py) == spot_y[i]
                    && act[1].fc == 16'd0) begin
                    checks++;
                    if (int'(act[1].addr) != spot_a[i]) begin
                        errors++;
                        $display("FAIL spot_addr x=%0d y=%0d: got %0d want %0d",
                                 spot_x[i], spot_y[i], act[1].addr, spot_a[i]);
                    end
                end
            end
        end
    end

    initial begin
        do_reset(4);
        // frame 1: first lines, then the vsync neighbourhood and the last line
        sweep_line(0);
        sweep_line(1);
        sweep_line(2);
        for (int v = 488; v <= 492; v++) sweep_line(v);
        sweep_line(523);
        // frame 2 starts: frame_count steps to 1
        sweep_line(0);
        // pixel enable high one clk in four; junk counts while disabled
        for (int h = 0; h < 800; h++) begin
            step(h, 1, 1'b1);
            for (int j = 0; j < 3; j++)
                step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
        end
        // out-of-range counts: blanking, syncs high, no strobes
        step(900, 100, 1'b1);
        step(100, 600, 1'b1);
        step(0, 600, 1'b1);
        step(0, 524, 1'b1);
        step(800, 0, 1'b1);
        step(700, 800, 1'b1);
        step(65535, 65535, 1'b1);
        // reset mid-line: the address counter restarts from 0 without an origin
        for (int h = 0; h < 50; h++) step(h, 3, 1'b1);
        do_reset(2);
        for (int h = 50; h < 100; h++) step(h, 3, 1'b1);
        for (int i = 0; i < 4; i++) step(700, 495, 1'b1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing decoder sitting directly downstream of the horizontal and vertical counters in the VGA pipeline. Consumes the free-running H/V count values and produces registered, active-low sync pulses, the active-video flag, pixel coordinates, a linear framebuffer read address, and line/frame start strobes. All outputs are delayed by a configurable number of pixel-enable steps so they stay aligned with framebuffer read data.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 32, vertical back porch (frame total 524)
- PIPE_DEPTH, 2, output latency in enabled steps; legal 1..3
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en  in  1  pixel-rate enable; pipeline advances only when high
- H_Count_Value  in  16  horizontal count, 0..799
- V_Count_Value  in  16  vertical count, 0..523
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high in the visible region
- pixel_x  out  10  visible column, 0 when blanked
- pixel_y  out  10  visible line, 0 when blanked
- fb_addr  out  19  linear framebuffer address, pixel_y*H_ACTIVE+pixel_x
- line_start  out  1  one-clk strobe at H=0
- frame_start  out  1  one-clk strobe at H=0, V=0
- frame_count  out  16  completed frames since reset, wraps

## Operation
- Decode, per input sample: active = H<H_ACTIVE && V<V_ACTIVE; hsync low when H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC (656..751); vsync low when V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC (490..491).
- Counts at or beyond the line/frame total are treated as blanking: syncs inactive (high), video_on 0, no strobes.
- pixel_x/pixel_y = H[9:0]/V[9:0] when active, else 0.
- fb_addr comes from an internal 19-bit address counter, not a multiplier. It clears to 0 when H=0,V=0 is sampled and increments by 1 after each sampled active pixel. The emitted value is the counter value at the sampled active pixel, and 0 when blanked.
- The address counter must equal y*640+x at every active pixel of a frame entered via H=0,V=0.
- frame_count increments by 1 on each emitted frame_start except the first after reset. Wraps 0xFFFF -> 0.
- Decoded values pass through a PIPE_DEPTH-stage shift register. All stages load only when en=1; with en=0 all stages and all level outputs hold.

## Timing
- Latency: an input sampled on an enabled clk edge appears at the outputs after PIPE_DEPTH enabled edges (including that edge).
- line_start and frame_start are high for exactly one clk cycle, on the cycle the corresponding stage reaches the output. They clear on the next clk even if en=0.
- Reset (rst=0 at a clk edge) takes priority over en:
  - every pipeline stage clears
  - hsync=1, vsync=1
  - video_on=0, pixel_x=0, pixel_y=0, fb_addr=0
  - line_start=0, frame_start=0, frame_count=0
  - address counter=0
- Reset mid-frame: outputs stay idle until PIPE_DEPTH enabled samples after release.
- fb_addr is valid once the first H=0,V=0 has been sampled after reset. Before that, the address counter counts from 0.

## Test plan
- Reset: hold rst=0 for 4 clk with random counts and en=1 -> all outputs at reset values. Release with H=V=0 and PIPE_DEPTH=2 -> frame_start high on the 2nd enabled edge, for 1 clk.
- Full-frame sweep, en=1 every clk:
  - hsync low for exactly 96 enabled cycles per line, starting 656+PIPE_DEPTH enabled samples after H=0
  - vsync low for lines 490..491 only
  - video_on high for 307200 samples per frame
- Address: sample H=639,V=479 -> fb_addr=307199. Next frame H=0,V=0 -> fb_addr=0, frame_count=1 (2nd frame_start).
- en gating, en high 1 clk in 4: outputs change only after enabled edges; line_start width still 1 clk; latency counted in enabled edges.
- Out of range: H=900,V=100 -> hsync=1, vsync=1, video_on=0, no strobes.
- PIPE_DEPTH=1 and 3: H=0,V=0 followed by active pixels -> frame_start and fb_addr=0 emitted 1 and 3 enabled edges later, respectively.
